// File: rtl/store_queue_if.sv
// Request and bus-beat channels of the store queue.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both 1. A producer raising valid keeps it and its payload stable until
// that edge; ready may change freely and never depends on valid. This holds
// for the request channel (in_*) and the bus channel (bus_*).
interface store_queue_if #(
    parameter int DW = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [31:0]     in_addr;
    logic [31:0]     in_data;
    logic            bus_valid;
    logic            bus_ready;
    logic [31:0]     bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic [DW/8-1:0] bus_be;

    // Environment side: issues requests, accepts bus beats.
    modport master (
        output in_valid, in_op, in_addr, in_data, bus_ready,
        input  in_ready, bus_valid, bus_addr, bus_wdata, bus_be
    );

    // Store-queue side.
    modport slave (
        input  in_valid, in_op, in_addr, in_data, bus_ready,
        output in_ready, bus_valid, bus_addr, bus_wdata, bus_be
    );
endinterface

// File: rtl/store_queue.sv
// Buffered store path: aligns store requests to bus lanes at enqueue time,
// queues them, and issues one or two bus beats per entry from a registered
// output stage.
module store_queue #(
    parameter int DW              = 32,
    parameter int DEPTH           = 4,
    parameter bit ALLOW_UNALIGNED = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    store_queue_if.slave           sq,
    output logic                   exc,
    output logic [31:0]            exc_addr,
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]             dbg_state
);
    localparam int L  = DW / 8;
    localparam int LW = $clog2(L);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BEAT1 = 2'd1,
        S_BEAT2 = 2'd2
    } state_t;

    // One queued store: lane data and byte enables span two bus words so a
    // lane-crossing store is just the upper half being non-zero.
    typedef struct packed {
        logic [31:0]     addr;
        logic [2*DW-1:0] data;
        logic [2*L-1:0]  be;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    entry_t          enq, head;

    logic [LW-1:0]   lane_o, lane_w, start;
    logic [1:0]      ab, rshift;
    logic [2:0]      nbytes;
    logic [3:0]      nmask;
    logic [31:0]     src, src_m;
    logic            is_store, misaligned, fault;
    logic            accept, push, pop, full;

    state_t          state;
    logic            bus_valid_q;
    logic [31:0]     bus_addr_q;
    logic [DW-1:0]   bus_wdata_q, b2_wdata;
    logic [L-1:0]    bus_be_q, b2_be;
    logic            b2_pend;

    // Decode the op into start lane, byte count and source byte offset, then
    // place the selected register bytes on their lanes.
    always_comb begin
        lane_o     = sq.in_addr[LW-1:0];
        lane_w     = lane_o & ~LW'(3);
        ab         = sq.in_addr[1:0];
        is_store   = 1'b1;
        misaligned = 1'b0;
        nbytes     = 3'd4;
        rshift     = 2'd0;
        start      = lane_o;
        case (sq.in_op)
            3'd1: misaligned = (ab != 2'd0);
            3'd2: begin
                nbytes     = 3'd2;
                misaligned = ab[0];
            end
            3'd3: nbytes = 3'd1;
            // swl: top ab+1 register bytes, starting at the word's first lane
            3'd4: begin
                nbytes = 3'd1 + {1'b0, ab};
                rshift = 2'd3 - ab;
                start  = lane_w;
            end
            // swr: low 4-ab register bytes, running up to the word's last lane
            3'd5: nbytes = 3'd4 - {1'b0, ab};
            default: is_store = 1'b0;
        endcase
        nmask = 4'((5'd1 << nbytes) - 5'd1);
        src   = sq.in_data >> {rshift, 3'b000};
        src_m = '0;
        for (int k = 0; k < 4; k++) begin
            src_m[8*k +: 8] = nmask[k] ? src[8*k +: 8] : 8'h00;
        end
        enq.addr = {sq.in_addr[31:LW], {LW{1'b0}}};
        enq.data = (2*DW)'(src_m) << {start, 3'b000};
        enq.be   = (2*L)'(nmask) << start;
    end

    assign fault     = misaligned && !ALLOW_UNALIGNED;
    assign full      = (count == FULL_CNT);
    assign accept    = sq.in_valid && sq.in_ready;
    assign push      = accept && is_store && !fault;
    assign head      = mem[rd_ptr];
    assign sq.in_ready = !full && !reset;

    // The output stage pulls the head whenever it is idle or its last beat
    // is being accepted; a pending second beat blocks the pull.
    always_comb begin
        pop = 1'b0;
        case (state)
            S_EMPTY: pop = (count != '0);
            S_BEAT1: pop = sq.bus_ready && !b2_pend && (count != '0);
            S_BEAT2: pop = sq.bus_ready && (count != '0);
            default: pop = 1'b0;
        endcase
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enq;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    // Output FSM with registered bus outputs and the held second beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_EMPTY;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            b2_wdata    <= '0;
            b2_be       <= '0;
            b2_pend     <= 1'b0;
        end else if (pop) begin
            state       <= S_BEAT1;
            bus_valid_q <= 1'b1;
            bus_addr_q  <= head.addr;
            bus_wdata_q <= head.data[DW-1:0];
            bus_be_q    <= head.be[L-1:0];
            b2_wdata    <= head.data[2*DW-1:DW];
            b2_be       <= head.be[2*L-1:L];
            b2_pend     <= |head.be[2*L-1:L];
        end else begin
            case (state)
                S_BEAT1: begin
                    if (sq.bus_ready) begin
                        if (b2_pend) begin
                            state       <= S_BEAT2;
                            bus_addr_q  <= bus_addr_q + 32'(L);
                            bus_wdata_q <= b2_wdata;
                            bus_be_q    <= b2_be;
                            b2_pend     <= 1'b0;
                        end else begin
                            state       <= S_EMPTY;
                            bus_valid_q <= 1'b0;
                        end
                    end
                end
                S_BEAT2: begin
                    if (sq.bus_ready) begin
                        state       <= S_EMPTY;
                        bus_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Misaligned-store pulse and faulting address.
    always_ff @(posedge clk) begin
        if (reset) begin
            exc      <= 1'b0;
            exc_addr <= '0;
        end else begin
            exc <= accept && fault;
            if (accept && fault) begin
                exc_addr <= sq.in_addr;
            end
        end
    end

    assign sq.bus_valid = bus_valid_q;
    assign sq.bus_addr  = bus_addr_q;
    assign sq.bus_wdata = bus_wdata_q;
    assign sq.bus_be    = bus_be_q;
    assign dbg_state    = state;
endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: three instances cover DW=32 trapping,
// DW=32 splitting and DW=64. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_store_queue;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    // Expected beats: {addr[31:0], wdata[63:0], be[7:0]}
    logic [103:0] exp_q[$];

    logic       exc0, exc1, exc2;
    logic [31:0] exc_addr0, exc_addr1, exc_addr2;
    logic [2:0] count0, count1, count2;
    logic [1:0] st0, st1, st2;

    store_queue_if #(.DW(32)) q0_if ();
    store_queue_if #(.DW(32)) q1_if ();
    store_queue_if #(.DW(64)) q2_if ();

    store_queue #(.DW(32), .DEPTH(4), .ALLOW_UNALIGNED(1'b0)) u0 (
        .clk(clk), .reset(reset), .sq(q0_if),
        .exc(exc0), .exc_addr(exc_addr0), .count(count0), .dbg_state(st0)
    );
    store_queue #(.DW(32), .DEPTH(4), .ALLOW_UNALIGNED(1'b1)) u1 (
        .clk(clk), .reset(reset), .sq(q1_if),
        .exc(exc1), .exc_addr(exc_addr1), .count(count1), .dbg_state(st1)
    );
    store_queue #(.DW(64), .DEPTH(4), .ALLOW_UNALIGNED(1'b0)) u2 (
        .clk(clk), .reset(reset), .sq(q2_if),
        .exc(exc2), .exc_addr(exc_addr2), .count(count2), .dbg_state(st2)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
        exp_q.push_back({a, d, be});
    endtask

    task automatic check_beat(input string tag, input logic vld, input logic [31:0] a,
                              input logic [63:0] d, input logic [7:0] be);
        logic [103:0] e;
        chk({tag, " valid"}, 64'(vld), 64'd1);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed beat %0h expected no beat queued", tag, a);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " addr"}, 64'(a), 64'(e[103:72]));
            chk({tag, " wdata"}, d, e[71:8]);
            chk({tag, " be"}, 64'(be), 64'(e[7:0]));
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic req(input int which, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d);
        case (which)
            0: begin q0_if.in_valid = 1'b1; q0_if.in_op = op; q0_if.in_addr = a; q0_if.in_data = d; end
            1: begin q1_if.in_valid = 1'b1; q1_if.in_op = op; q1_if.in_addr = a; q1_if.in_data = d; end
            default: begin q2_if.in_valid = 1'b1; q2_if.in_op = op; q2_if.in_addr = a; q2_if.in_data = d; end
        endcase
    endtask

    task automatic idle();
        q0_if.in_valid = 1'b0; q0_if.in_op = 3'd0;
        q1_if.in_valid = 1'b0; q1_if.in_op = 3'd0;
        q2_if.in_valid = 1'b0; q2_if.in_op = 3'd0;
    endtask

    initial begin
        idle();
        q0_if.in_addr = '0; q0_if.in_data = '0; q0_if.bus_ready = 1'b0;
        q1_if.in_addr = '0; q1_if.in_data = '0; q1_if.bus_ready = 1'b0;
        q2_if.in_addr = '0; q2_if.in_data = '0; q2_if.bus_ready = 1'b0;
        reset = 1'b1;
        step();
        step();

        // Reset state
        chk("rst bus_valid", 64'(q0_if.bus_valid), 64'd0);
        chk("rst bus_addr", 64'(q0_if.bus_addr), 64'd0);
        chk("rst bus_wdata", 64'(q0_if.bus_wdata), 64'd0);
        chk("rst bus_be", 64'(q0_if.bus_be), 64'd0);
        chk("rst exc", 64'(exc0), 64'd0);
        chk("rst exc_addr", 64'(exc_addr0), 64'd0);
        chk("rst count", 64'(count0), 64'd0);
        chk("rst in_ready low", 64'(q0_if.in_ready), 64'd0);
        reset = 1'b0;
        step();
        chk("in_ready after reset", 64'(q0_if.in_ready), 64'd1);

        // sb to 0x1003: one-cycle latency, lane 3, hold while stalled
        req(0, 3'd3, 32'h1003, 32'h0000_00AB);
        expect_beat(32'h1000, 64'hAB00_0000, 8'b1000);
        step();
        idle();
        chk("sb count", 64'(count0), 64'd1);
        chk("sb not yet valid", 64'(q0_if.bus_valid), 64'd0);
        step();
        check_beat("sb", q0_if.bus_valid, q0_if.bus_addr, 64'(q0_if.bus_wdata), 8'(q0_if.bus_be));
        chk("sb count after load", 64'(count0), 64'd0);
        step();
        chk("sb hold valid", 64'(q0_if.bus_valid), 64'd1);
        chk("sb hold wdata", 64'(q0_if.bus_wdata), 64'hAB00_0000);
        chk("sb hold addr", 64'(q0_if.bus_addr), 64'h1000);
        q0_if.bus_ready = 1'b1;
        step();
        chk("sb drained", 64'(q0_if.bus_valid), 64'd0);
        q0_if.bus_ready = 1'b0;

        // swl then swr to 0x2001
        req(0, 3'd4, 32'h2001, 32'h1122_3344);
        expect_beat(32'h2000, 64'h0000_1122, 8'b0011);
        step();
        req(0, 3'd5, 32'h2001, 32'h1122_3344);
        expect_beat(32'h2000, 64'h2233_4400, 8'b1110);
        step();
        idle();
        check_beat("swl", q0_if.bus_valid, q0_if.bus_addr, 64'(q0_if.bus_wdata), 8'(q0_if.bus_be));
        chk("swl/swr count", 64'(count0), 64'd1);
        q0_if.bus_ready = 1'b1;
        step();
        check_beat("swr", q0_if.bus_valid, q0_if.bus_addr, 64'(q0_if.bus_wdata), 8'(q0_if.bus_be));
        chk("swr count", 64'(count0), 64'd0);
        step();
        chk("swr drained", 64'(q0_if.bus_valid), 64'd0);
        q0_if.bus_ready = 1'b0;

        // Misaligned sh traps and is dropped
        req(0, 3'd2, 32'h5001, 32'h0000_1234);
        step();
        idle();
        chk("sh trap exc", 64'(exc0), 64'd1);
        chk("sh trap exc_addr", 64'(exc_addr0), 64'h5001);
        chk("sh trap count", 64'(count0), 64'd0);
        step();
        chk("sh trap exc pulse", 64'(exc0), 64'd0);
        chk("sh trap no beat", 64'(q0_if.bus_valid), 64'd0);

        // Op 6 is accepted and discarded
        req(0, 3'd6, 32'h5100, 32'hFFFF_FFFF);
        chk("op6 ready", 64'(q0_if.in_ready), 64'd1);
        step();
        idle();
        chk("op6 count", 64'(count0), 64'd0);
        chk("op6 exc", 64'(exc0), 64'd0);
        step();
        chk("op6 no beat", 64'(q0_if.bus_valid), 64'd0);

        // Split sw to 0x3001 with bus_ready held high
        q1_if.bus_ready = 1'b1;
        req(1, 3'd1, 32'h3001, 32'hAABB_CCDD);
        expect_beat(32'h3000, 64'hBBCC_DD00, 8'b1110);
        expect_beat(32'h3004, 64'h0000_00AA, 8'b0001);
        step();
        idle();
        chk("split no exc", 64'(exc1), 64'd0);
        chk("split count", 64'(count1), 64'd1);
        step();
        check_beat("split b1", q1_if.bus_valid, q1_if.bus_addr, 64'(q1_if.bus_wdata), 8'(q1_if.bus_be));
        step();
        check_beat("split b2", q1_if.bus_valid, q1_if.bus_addr, 64'(q1_if.bus_wdata), 8'(q1_if.bus_be));
        step();
        chk("split drained", 64'(q1_if.bus_valid), 64'd0);

        // Misaligned sh that stays within the word: one beat, no exception
        req(1, 3'd2, 32'h3001, 32'h0000_5678);
        expect_beat(32'h3000, 64'h0056_7800, 8'b0110);
        step();
        idle();
        chk("sh inword exc", 64'(exc1), 64'd0);
        step();
        check_beat("sh inword", q1_if.bus_valid, q1_if.bus_addr, 64'(q1_if.bus_wdata), 8'(q1_if.bus_be));
        step();
        chk("sh inword single beat", 64'(q1_if.bus_valid), 64'd0);

        // DW=64: sh to 0x4006, then sw to 0x4004
        req(2, 3'd2, 32'h4006, 32'h0000_BEEF);
        expect_beat(32'h4000, 64'hBEEF_0000_0000_0000, 8'hC0);
        step();
        idle();
        step();
        check_beat("dw64 sh", q2_if.bus_valid, q2_if.bus_addr, q2_if.bus_wdata, q2_if.bus_be);
        q2_if.bus_ready = 1'b1;
        req(2, 3'd1, 32'h4004, 32'h0102_0304);
        expect_beat(32'h4000, 64'h0102_0304_0000_0000, 8'hF0);
        step();
        idle();
        chk("dw64 sh drained", 64'(q2_if.bus_valid), 64'd0);
        step();
        check_beat("dw64 sw", q2_if.bus_valid, q2_if.bus_addr, q2_if.bus_wdata, q2_if.bus_be);
        step();
        chk("dw64 sw drained", 64'(q2_if.bus_valid), 64'd0);

        // Fill with bus stalled: 4 in FIFO plus 1 in the output stage
        q0_if.bus_ready = 1'b0;
        expect_beat(32'h6000, 64'h0, 8'b0001);
        for (int i = 0; i < 5; i++) begin
            req(0, 3'd3, 32'h6000 + 32'(i), 32'(i));
            chk("fill in_ready", 64'(q0_if.in_ready), 64'd1);
            step();
        end
        chk("full in_ready", 64'(q0_if.in_ready), 64'd0);
        chk("full count", 64'(count0), 64'd4);
        idle();
        check_beat("full head", q0_if.bus_valid, q0_if.bus_addr, 64'(q0_if.bus_wdata), 8'(q0_if.bus_be));

        // Reset mid-stall flushes everything
        reset = 1'b1;
        step();
        chk("flush bus_valid", 64'(q0_if.bus_valid), 64'd0);
        chk("flush count", 64'(count0), 64'd0);
        reset = 1'b0;
        q0_if.bus_ready = 1'b1;
        step();
        step();
        chk("flush no beat", 64'(q0_if.bus_valid), 64'd0);
        chk("flush count stays", 64'(count0), 64'd0);
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/store_queue.md
# store_queue

Buffered store path between the EX/MEM stage and the data-memory bus. Accepts store requests (sw/sh/sb/swl/swr) on a valid/ready handshake, queues them in a parametrised FIFO, and issues bus beats with lane-shifted data and a per-byte write mask. Replaces the fixed 32-bit, combinational store alignment with a configurable bus width and optional splitting of unaligned stores into two beats.

## Interface
Parameters:
- DW, 32: bus data width; 32 or 64.
- DEPTH, 4: FIFO entries; power of 2, 2..16.
- ALLOW_UNALIGNED, 0: 1 = split lane-crossing sw/sh into two beats; 0 = raise exception and drop.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  store request present.
- in_ready  out  1  `!full && !reset`.
- in_op  in  3  0 none, 1 sw, 2 sh, 3 sb, 4 swl, 5 swr; 6 and 7 behave as none.
- in_addr  in  32  byte address.
- in_data  in  32  register value; store bytes are taken from the low end.
- bus_valid  out  1  beat present.
- bus_ready  in  1  beat accepted when `bus_valid && bus_ready`.
- bus_addr  out  32  beat address, aligned to DW/8.
- bus_wdata  out  DW  lane-shifted data.
- bus_be  out  DW/8  byte enables; bit i covers lane i (little-endian).
- exc  out  1  one-cycle misaligned-store pulse.
- exc_addr  out  32  address of the last faulting request.
- count  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the output stage.

## Operation
- Handshake: a request is accepted on `in_valid && in_ready`. Ops 0, 6 and 7 are accepted and discarded.
- Enqueue and dequeue in the same cycle are allowed; count is unchanged. When full, in_ready is 0 even if a dequeue occurs that cycle (no pass-through).
- Lane math: L = DW/8 and o = addr mod L.
  - sw: n=4 bytes, start o.
  - sh: n=2, start o.
  - sb: n=1, start o.
  - swl: b = addr[1:0], word base w = addr & ~3. Writes lanes (w mod L)..(w mod L)+b with the top b+1 bytes of in_data.
  - swr: b = addr[1:0]. Writes lanes o..(w mod L)+3 with the low 4-b bytes of in_data.
  - Data is placed so that register byte k lands on lane start+k.
- Misalignment: sw with addr[1:0]!=0, or sh with addr[0]!=0.
  - ALLOW_UNALIGNED=0: the request is accepted but not enqueued. exc=1 for the cycle after acceptance, and exc_addr is loaded with in_addr.
  - ALLOW_UNALIGNED=1: no exception.
    - If o+n <= L: single beat.
    - Else beat 1 goes to addr & ~(L-1), lanes o..L-1, carrying the low L-o bytes.
    - Beat 2 goes to beat-1 address + L, lanes 0..o+n-L-1, carrying the remaining high bytes.
- swl/swr never split and never fault.
- Output FSM states:
  - EMPTY: bus_valid=0. If the FIFO is non-empty, load the head into the output registers and go to BEAT1.
  - BEAT1: on bus_ready, go to BEAT2 if the entry splits. Otherwise load the next head (BEAT1) or go to EMPTY.
  - BEAT2: on bus_ready, load the next head (BEAT1) or go to EMPTY.
- While `bus_valid && !bus_ready`, bus_addr, bus_wdata and bus_be hold stable.
- Reset:
  - Flushes the FIFO, the output stage and any pending beat 2, in any state.
  - Outputs after reset: bus_valid=0, bus_addr=0, bus_wdata=0, bus_be=0, exc=0, exc_addr=0, count=0.
  - in_ready=1 from the first cycle after reset deasserts.

## Timing
- Latency: a request accepted at edge N into an empty queue with an idle output stage gives bus_valid=1 after edge N+1.
- Back-to-back: with bus_ready held at 1, one beat is issued per cycle, including the second beat of a split.
- exc: high exactly one cycle, starting after the acceptance edge.
- count: updates on the same edge as the handshake.
- Bus outputs are registered; in_ready depends only on count and reset.

## Test plan
- DW=32, sb to 0x1003, data 0x000000AB -> bus_addr 0x1000, be 0b1000, wdata 0xAB000000, bus_valid one cycle after acceptance.
- DW=32, swl to 0x2001 with 0x11223344, then swr to 0x2001 with 0x11223344:
  - swl beat: be 0b0011, wdata 0x00001122.
  - swr beat: be 0b1110, wdata 0x22334400.
- DW=32, ALLOW_UNALIGNED=1, sw to 0x3001 with 0xAABBCCDD, bus_ready=1:
  - beat 1: 0x3000, be 0b1110, wdata 0xBBCCDD00.
  - beat 2: 0x3004, be 0b0001, wdata 0x000000AA.
- DW=64, sh to 0x4006 with 0xBEEF -> bus_addr 0x4000, be 0x40|0x80=0xC0, wdata 0xBEEF000000000000.
- ALLOW_UNALIGNED=0, sh to 0x5001:
  - exc pulses 1 cycle and exc_addr=0x5001.
  - No beat is issued and count stays 0.
- DEPTH=4, bus_ready=0, five sb requests:
  - in_ready drops after 4 are enqueued plus 1 in the output stage.
  - Asserting reset mid-stall -> bus_valid=0 and count=0 next cycle; the remaining entries are never issued.
